fp_mul_rr_scheduler: RTL and testbench

//  Shares one combinational 8-bit FP multiplier (1 sign, 3-bit exp, 4-bit mantissa) between NREQ requesters.

---
 rtl/fp_mul_rr_scheduler.sv | 121 ++++++++++++
 tb/tb_fp_mul_rr_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_rr_scheduler.sv
// Round-robin scheduler sharing one combinational 8-bit FP multiplier between NREQ requesters.
// Operands are registered toward the multiplier; the result is captured and held for its owner.
module fp_mul_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [7:0]        mul_result,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          owner_q;
    logic [2:0]              cnt_q;
    logic [7:0]              mul_a_q, mul_b_q, rsp_data_q;
    logic [IDW-1:0]          rsp_id_q;
    logic [15:0]             op_cnt_q;
    logic [NREQ-1:0][7:0]    a_lane, b_lane;

    logic                    gnt_vld;
    logic [IDW-1:0]          gnt_idx;
    logic                    accept, capture, rsp_done;

    assign a_lane = req_a;
    assign b_lane = req_b;

    // Search starts one past the last owner so it is considered last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_vld && req_valid[IDW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    assign accept   = (state_q == IDLE) && gnt_vld;
    assign capture  = (state_q == CALC) && (cnt_q == 3'(MUL_LAT - 1));
    assign rsp_done = (state_q == RESP) && rsp_ready[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = CALC;
            CALC:    if (capture)  state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IDW'(NREQ - 1);
            owner_q    <= '0;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            op_cnt_q   <= '0;
        end else begin
            if (accept) begin
                mul_a_q <= a_lane[gnt_idx];
                mul_b_q <= b_lane[gnt_idx];
                owner_q <= gnt_idx;
                ptr_q   <= gnt_idx;
                cnt_q   <= '0;
            end
            if (state_q == CALC) cnt_q <= cnt_q + 3'd1;
            if (capture) begin
                rsp_data_q <= mul_result;
                rsp_id_q   <= owner_q;
            end
            if (rsp_done) op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    // req_ready is combinational, so it must be gated explicitly while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign busy     = (state_q != IDLE);
    assign op_count = op_cnt_q;

endmodule

// File: tb/tb_fp_mul_rr_scheduler.sv
// Directed bench: two scheduler instances (MUL_LAT=1 with a multiplier model, MUL_LAT=3 driven by hand).
module tb_fp_mul_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, rsp_ready, req_ready, rsp_valid;
    logic [31:0] req_a, req_b;
    logic [7:0]  mul_a, mul_b, mul_result, rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] op_count;

    logic [3:0]  req_valid3, rsp_ready3, req_ready3, rsp_valid3;
    logic [7:0]  mul_a3, mul_b3, mul_result3, rsp_data3;
    logic [1:0]  rsp_id3;
    logic        busy3;
    logic [15:0] op_count3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 1-3-4 FP multiply (bias 3, truncating), used as the attached multiplier.
    function automatic logic [7:0] fp_mul(input logic [7:0] a, input logic [7:0] b);
        logic       s;
        logic [9:0] p;
        int         e;
        s = a[7] ^ b[7];
        if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return {s, 7'd0};
        p = {5'd0, 1'b1, a[3:0]} * {5'd0, 1'b1, b[3:0]};
        e = int'(a[6:4]) + int'(b[6:4]) - 3 + (p[9] ? 1 : 0);
        if (e <= 0) return {s, 7'd0};
        if (e > 7)  return {s, 7'h7F};
        return p[9] ? {s, 3'(e), p[8:5]} : {s, 3'(e), p[7:4]};
    endfunction

    assign mul_result = fp_mul(mul_a, mul_b);

    fp_mul_rr_scheduler #(.NREQ(4), .IDW(2), .MUL_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    fp_mul_rr_scheduler #(.NREQ(4), .IDW(2), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a3), .mul_b(mul_b3),
        .mul_result(mul_result3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_id(rsp_id3), .busy(busy3), .op_count(op_count3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 4'b1111;
        rsp_ready   = 4'b0000;
        req_a       = '0;
        req_b       = '0;
        req_valid3  = 4'b0000;
        rsp_ready3  = 4'b0000;
        mul_result3 = 8'h11;

        // Reset state, with requests pending to show req_ready is gated
        step();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_mul_a",     32'(mul_a),     32'h0);
        chk("rst_rsp_data",  32'(rsp_data),  32'h0);
        chk("rst_op_count",  32'(op_count),  32'h0);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        step();

        // Single op on requester 0
        req_a = 32'h0000_0030; req_b = 32'h0000_0030;
        req_valid = 4'b0001;
        #1 chk("single_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        chk("single_busy",   32'(busy),      32'h1);
        chk("single_mul_a",  32'(mul_a),     32'h30);
        chk("single_rv_calc", 32'(rsp_valid), 32'h0);
        step();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_data",  32'(rsp_data),  32'h30);
        chk("single_rsp_id",    32'(rsp_id),    32'h0);
        rsp_ready = 4'b0001;
        step();
        rsp_ready = 4'b0000;
        chk("single_op_count", 32'(op_count), 32'h1);
        chk("single_idle",     32'(busy),     32'h0);

        // Zero pass-through on requester 2
        req_a = 32'h0000_0000; req_b = 32'h0035_0000;
        req_valid = 4'b0100;
        #1 chk("zero_req_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        step();
        chk("zero_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("zero_rsp_data",  32'(rsp_data),  32'h00);
        chk("zero_rsp_id",    32'(rsp_id),    32'h2);
        rsp_ready = 4'b0100;
        step();
        rsp_ready = 4'b0000;
        chk("zero_op_count", 32'(op_count), 32'h2);

        // Response backpressure on requester 1; non-owner rsp_ready must be ignored
        req_a = 32'h0000_3000; req_b = 32'h0000_3000;
        req_valid = 4'b0010;
        #1 chk("bp_req_ready", 32'(req_ready), 32'h2);
        step();
        step();
        req_valid = 4'b1101;
        rsp_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("bp_rsp_data",  32'(rsp_data),  32'h30);
            chk("bp_rsp_id",    32'(rsp_id),    32'h1);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_busy",      32'(busy),      32'h1);
            chk("bp_op_count",  32'(op_count),  32'h2);
            step();
        end
        rsp_ready = 4'b0010;
        step();
        chk("bp_release_idle",  32'(busy),     32'h0);
        chk("bp_release_count", 32'(op_count), 32'h3);
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        step();

        // Reset mid-op: requester 3 accepted, reset asserted while in CALC
        req_a = 32'h3000_0000; req_b = 32'h3000_0000;
        req_valid = 4'b1000;
        #1 chk("rmid_req_ready", 32'(req_ready), 32'h8);
        step();
        chk("rmid_in_calc", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rmid_busy",      32'(busy),      32'h0);
        chk("rmid_req_ready", 32'(req_ready), 32'h0);
        chk("rmid_mul_a",     32'(mul_a),     32'h0);
        chk("rmid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rmid_op_count",  32'(op_count),  32'h0);
        step();
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmid_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Round-robin: all hold requests, grants 0,1,2,3,0 three cycles apart
        req_a = 32'h3030_3030;
        req_b = 32'h3030_B030;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [1:0] id;
            id = 2'(n % 4);
            #1 chk("rr_grant", 32'(req_ready), 32'(4'b0001 << id));
            step();
            chk("rr_no_ready_calc", 32'(req_ready), 32'h0);
            step();
            chk("rr_rsp_id",    32'(rsp_id),    32'(id));
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << id));
            chk("rr_rsp_data",  32'(rsp_data),  (id == 2'd1) ? 32'hB0 : 32'h30);
            step();
        end
        req_valid = 4'b0000;
        chk("rr_op_count", 32'(op_count), 32'h5);

        // op_count wrap from 0xFFFF
        u_dut.op_cnt_q = 16'hFFFF;
        req_a = 32'h0000_0030; req_b = 32'h0000_0030;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        step();
        step();
        chk("wrap_op_count", 32'(op_count), 32'h0);
        rsp_ready = 4'b0000;

        // MUL_LAT=3: operands held, only the final CALC cycle's mul_result is captured
        req_a = 32'h0000_0012; req_b = 32'h0000_0034;
        req_valid3 = 4'b0001;
        #1 chk("lat3_req_ready", 32'(req_ready3), 32'h1);
        step();
        req_valid3 = 4'b0000;
        chk("lat3_mul_a_c0", 32'(mul_a3), 32'h12);
        chk("lat3_mul_b_c0", 32'(mul_b3), 32'h34);
        chk("lat3_rv_c0",    32'(rsp_valid3), 32'h0);
        step();
        mul_result3 = 8'h22;
        chk("lat3_mul_a_c1", 32'(mul_a3), 32'h12);
        chk("lat3_rv_c1",    32'(rsp_valid3), 32'h0);
        step();
        mul_result3 = 8'h5A;
        chk("lat3_mul_b_c2", 32'(mul_b3), 32'h34);
        chk("lat3_rv_c2",    32'(rsp_valid3), 32'h0);
        step();
        mul_result3 = 8'h77;
        chk("lat3_rsp_valid", 32'(rsp_valid3), 32'h1);
        chk("lat3_rsp_data",  32'(rsp_data3),  32'h5A);
        rsp_ready3 = 4'b0001;
        step();
        chk("lat3_op_count", 32'(op_count3), 32'h1);
        chk("lat3_idle",     32'(busy3),     32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
